// File: rtl/otter_io_pkg.sv
// otter_io_pkg: shared constants and types for the OTTER memory-mapped timer.
// Holds register offsets, CTRL bit positions, the default base address,
// the timer state enum and the bus address decoder.
package otter_io_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1100_0200;

    // Register byte offsets from BASE_ADDR
    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_LOAD   = 5'h04;
    localparam logic [4:0] OFF_COUNT  = 5'h08;
    localparam logic [4:0] OFF_STATUS = 5'h0C;
    localparam logic [4:0] OFF_PRESC  = 5'h10;

    // CTRL bit indices
    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;

    localparam int PRESC_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_e;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CTRL,
        SEL_LOAD,
        SEL_COUNT,
        SEL_STATUS,
        SEL_PRESC
    } reg_sel_e;

    // Map a CPU byte address onto a timer register; the low two address
    // bits are dropped so any byte lane of a word selects that word.
    function automatic reg_sel_e decode_addr(input logic [31:0] addr,
                                             input logic [31:0] base);
        logic [31:0] off;
        off = {addr[31:2], 2'b00} - base;
        decode_addr = SEL_NONE;
        if (off[31:5] == 27'd0) begin
            case (off[4:0])
                OFF_CTRL:   decode_addr = SEL_CTRL;
                OFF_LOAD:   decode_addr = SEL_LOAD;
                OFF_COUNT:  decode_addr = SEL_COUNT;
                OFF_STATUS: decode_addr = SEL_STATUS;
                OFF_PRESC:  decode_addr = SEL_PRESC;
                default:    decode_addr = SEL_NONE;
            endcase
        end
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the RUN-state clock by (presc+1).
// Counts 0..presc and emits a one-cycle tick when the count equals presc,
// then wraps to 0. Held at 0 while disabled or when clear is asserted.
module timer_prescaler
    import otter_io_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               clear,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == presc);

    // Next prescaler count: wrap on tick, park at 0 when stopped
    always_comb begin
        cnt_d = cnt_q;
        if (!enable || clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Prescaler count register with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/otter_io_timer.sv
// otter_io_timer: memory-mapped down-counting timer with interrupt.
// Registers: CTRL (EN/AUTO/IE), LOAD, COUNT, STATUS (PEND), PRESC.
// Build option OTTER_TIMER_PRESCALE_EN: when defined, PRESC is a writable
// 8-bit register driving timer_prescaler; otherwise the timer ticks every
// RUN cycle and PRESC reads 0.
module otter_io_timer
    import otter_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        INTR
);

    timer_state_e       state_q, state_d;
    logic               auto_q, auto_d;
    logic               ie_q, ie_d;
    logic [31:0]        load_q, load_d;
    logic [31:0]        count_q, count_d;
    logic               pend_q, pend_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               intr_q, intr_d;

    reg_sel_e sel;
    logic     wr_ctrl, wr_load, wr_count, wr_status;
    logic     tick, expiry;

    assign sel       = decode_addr(IOBUS_ADDR, BASE_ADDR);
    assign wr_ctrl   = IOBUS_WR && (sel == SEL_CTRL);
    assign wr_load   = IOBUS_WR && (sel == SEL_LOAD);
    assign wr_count  = IOBUS_WR && (sel == SEL_COUNT);
    assign wr_status = IOBUS_WR && (sel == SEL_STATUS);

`ifdef OTTER_TIMER_PRESCALE_EN
    // Prescaler restarts from 0 whenever the timer is about to go idle
    timer_prescaler u_prescaler (
        .clk    (CLK),
        .rst_n  (RST_N),
        .enable (state_q == RUN),
        .clear  (state_d == IDLE),
        .presc  (presc_q),
        .tick   (tick)
    );
`else
    assign tick = (state_q == RUN);
`endif

    // Expiry is a tick that finds the counter already at zero
    assign expiry = tick && (count_q == 32'd0);

    // Next-state: CPU CTRL write wins over a one-shot expiry
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wr_ctrl && IOBUS_OUT[CTRL_EN]) state_d = RUN;
            end
            RUN: begin
                if (wr_ctrl) begin
                    state_d = IOBUS_OUT[CTRL_EN] ? RUN : IDLE;
                end else if (expiry && !auto_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register updates, counter arithmetic, read mux and interrupt level
    always_comb begin
        auto_d  = auto_q;
        ie_d    = ie_q;
        load_d  = load_q;
        count_d = count_q;
        pend_d  = pend_q;
        presc_d = presc_q;
        rdata_d = 32'd0;

        // Tick effect first so CPU writes below can override it
        if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else if (auto_q) begin
                count_d = load_q;
            end
        end

        if (wr_ctrl) begin
            auto_d = IOBUS_OUT[CTRL_AUTO];
            ie_d   = IOBUS_OUT[CTRL_IE];
        end
        if (wr_load)  load_d  = IOBUS_OUT;
        if (wr_count) count_d = IOBUS_OUT;

        // A clear racing an expiry loses: the new event stays pending
        if (wr_status && IOBUS_OUT[0]) pend_d = 1'b0;
        if (expiry)                    pend_d = 1'b1;

`ifdef OTTER_TIMER_PRESCALE_EN
        if (IOBUS_WR && (sel == SEL_PRESC)) presc_d = IOBUS_OUT[PRESC_W-1:0];
`else
        presc_d = '0;
`endif

        case (sel)
            SEL_CTRL:   rdata_d = {29'd0, ie_q, auto_q, state_q == RUN};
            SEL_LOAD:   rdata_d = load_q;
            SEL_COUNT:  rdata_d = count_q;
            SEL_STATUS: rdata_d = {31'd0, pend_q};
            SEL_PRESC:  rdata_d = {{(32-PRESC_W){1'b0}}, presc_q};
            default:    rdata_d = 32'd0;
        endcase

        intr_d = pend_d && ie_d;
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            auto_q  <= 1'b0;
            ie_q    <= 1'b0;
            load_q  <= 32'd0;
            count_q <= 32'd0;
            pend_q  <= 1'b0;
            presc_q <= '0;
            rdata_q <= 32'd0;
            intr_q  <= 1'b0;
        end else begin
            auto_q  <= auto_d;
            ie_q    <= ie_d;
            load_q  <= load_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            presc_q <= presc_d;
            rdata_q <= rdata_d;
            intr_q  <= intr_d;
        end
    end

    assign IOBUS_IN = rdata_q;
    assign INTR     = intr_q;

endmodule

// File: tb/tb_otter_io_timer.sv
// tb_otter_io_timer: scoreboard bench for otter_io_timer.
// Each bus cycle pushes the expected IOBUS_IN/INTR into queues; a negedge
// monitor pops and compares. Expectations come from a cycle-count model
// (tick when cycles-in-RUN mod (PRESC+1) == PRESC) or from hand constants.
module tb_otter_io_timer;

    localparam logic [31:0] B       = 32'h1100_0200;
    localparam logic [31:0] A_CTRL  = B;
    localparam logic [31:0] A_LOAD  = B + 32'h4;
    localparam logic [31:0] A_COUNT = B + 32'h8;
    localparam logic [31:0] A_STAT  = B + 32'hC;
    localparam logic [31:0] A_PRESC = B + 32'h10;
`ifdef OTTER_TIMER_PRESCALE_EN
    localparam bit PRESC_ON = 1'b1;
`else
    localparam bit PRESC_ON = 1'b0;
`endif
    localparam int PW = PRESC_ON ? 4 : 0;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        wr = 1'b0;
    logic [31:0] iobus_in;
    logic        intr;

    otter_io_timer #(.BASE_ADDR(B)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .IOBUS_ADDR (addr),
        .IOBUS_OUT  (wdata),
        .IOBUS_WR   (wr),
        .IOBUS_IN   (iobus_in),
        .INTR       (intr)
    );

    always #5 CLK = ~CLK;

    // Reference model state
    bit          m_en, m_auto, m_ie, m_pend;
    logic [31:0] m_load, m_count;
    logic [7:0]  m_presc;
    int unsigned m_run;

    logic [31:0] q_rd[$];
    bit          q_it[$];
    string       q_tag[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] off;
        off = {a[31:2], 2'b00} - B;
        case (off)
            32'h00:  return {29'd0, m_ie, m_auto, m_en};
            32'h04:  return m_load;
            32'h08:  return m_count;
            32'h0C:  return {31'd0, m_pend};
            32'h10:  return PRESC_ON ? {24'd0, m_presc} : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_clear();
        m_en = 0; m_auto = 0; m_ie = 0; m_pend = 0;
        m_load = 0; m_count = 0; m_presc = 0; m_run = 0;
    endtask

    // One bus cycle: drive, predict, clock, advance model, push expectation
    task automatic op(input logic [31:0] a, input logic [31:0] d, input bit w,
                      input string tag, input bit use_c, input logic [31:0] cval);
        logic [31:0] erd, off, n_load, n_count;
        logic [7:0]  n_presc;
        bit          tick, expiry, n_en, n_auto, n_ie, n_pend;
        int unsigned p, n_run;
        addr = a; wdata = d; wr = w;
        erd = use_c ? cval : m_read(a);
        @(posedge CLK);
        p       = PRESC_ON ? int'(m_presc) : 0;
        tick    = m_en && ((m_run % (p + 1)) == p);
        expiry  = tick && (m_count == 0);
        n_count = m_count;
        if (tick) n_count = (m_count == 0) ? (m_auto ? m_load : 32'd0) : m_count - 1;
        n_en    = m_en && !(expiry && !m_auto);
        n_auto  = m_auto; n_ie = m_ie; n_load = m_load; n_presc = m_presc;
        n_pend  = m_pend || expiry;
        n_run   = m_en ? m_run + 1 : 0;
        off     = {a[31:2], 2'b00} - B;
        if (w) begin
            case (off)
                32'h00: begin n_en = d[0]; n_auto = d[1]; n_ie = d[2]; end
                32'h04: n_load = d;
                32'h08: n_count = d;
                32'h0C: if (d[0]) n_pend = expiry;
                32'h10: if (PRESC_ON) n_presc = d[7:0];
                default: ;
            endcase
        end
        if (!n_en) n_run = 0;
        m_en = n_en; m_auto = n_auto; m_ie = n_ie; m_pend = n_pend;
        m_load = n_load; m_count = n_count; m_presc = n_presc; m_run = n_run;
        q_rd.push_back(erd);
        q_it.push_back(n_pend && n_ie);
        q_tag.push_back(tag);
        #1;
        addr = 32'd0; wdata = 32'd0; wr = 1'b0;
    endtask

    task automatic wrt(input logic [31:0] a, input logic [31:0] d, input string tag);
        op(a, d, 1'b1, tag, 1'b0, 32'd0);
    endtask
    task automatic rd(input logic [31:0] a, input string tag);
        op(a, 32'd0, 1'b0, tag, 1'b0, 32'd0);
    endtask
    task automatic rdc(input logic [31:0] a, input logic [31:0] c, input string tag);
        op(a, 32'd0, 1'b0, tag, 1'b1, c);
    endtask

    task automatic do_reset();
        RST_N = 1'b0; addr = 32'd0; wr = 1'b0;
        @(posedge CLK);
        model_clear();
        q_rd.push_back(32'd0); q_it.push_back(1'b0); q_tag.push_back("reset");
        #1;
        RST_N = 1'b1;
    endtask

    // Monitor: one expectation per clock, checked on the falling edge
    always @(negedge CLK) begin : mon
        logic [31:0] er;
        bit          ei;
        string       t;
        if (q_rd.size() != 0) begin
            er = q_rd.pop_front();
            ei = q_it.pop_front();
            t  = q_tag.pop_front();
            n_cmp++;
            if (iobus_in !== er) begin
                n_bad++;
                $display("FAIL %s IOBUS_IN got %h want %h", t, iobus_in, er);
            end
            n_cmp++;
            if (intr !== ei) begin
                n_bad++;
                $display("FAIL %s INTR got %b want %b", t, intr, ei);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int unsigned r;
        model_clear();
        do_reset();
        rdc(A_CTRL, 0, "rst_ctrl");
        rdc(A_COUNT, 0, "rst_count");
        rdc(A_STAT, 0, "rst_status");

        // Auto-reload, period 4 with PRESC=0
        wrt(A_LOAD, 3, "t1_load");
        wrt(A_PRESC, 0, "t1_presc");
        wrt(A_COUNT, 3, "t1_count");
        wrt(A_CTRL, 7, "t1_ctrl");
        for (int k = 1; k <= 4; k++) rdc(A_STAT, 0, "t1_pend_low");
        rdc(A_STAT, 1, "t1_pend_rise");
        wrt(A_STAT, 1, "t1_clr");
        rdc(A_COUNT, 1, "t1_reload");
        wrt(A_STAT, 1, "t1_clr_on_expiry");
        rdc(A_STAT, 1, "t1_pend_kept");
        wrt(A_STAT, 1, "t1_clr_intr_drop");
        rdc(A_STAT, 0, "t1_pend_cleared");
        rdc(A_COUNT, 0, "t1_count_zero");
        rdc(A_STAT, 1, "t1_repeat");
        rdc(A_COUNT, 2, "t1_count_after");
        wrt(A_CTRL, 0, "t1_stop");

        // One-shot
        wrt(A_STAT, 1, "t2_clr");
        wrt(A_COUNT, 2, "t2_count");
        wrt(A_CTRL, 5, "t2_ctrl");
        for (int k = 1; k <= 3; k++) rd(A_COUNT, "t2_count_rd");
        rdc(A_CTRL, 4, "t2_en_clear");
        rdc(A_COUNT, 0, "t2_count_stay");
        rdc(A_STAT, 1, "t2_pend");
        wrt(A_STAT, 1, "t2_clr2");
        for (int k = 1; k <= 3; k++) rdc(A_STAT, 0, "t2_single_expiry");
        rdc(A_COUNT, 0, "t2_count_zero");

        // Prescaled one-shot
        wrt(A_CTRL, 0, "t3_stop");
        wrt(A_STAT, 1, "t3_clr");
        wrt(A_PRESC, 4, "t3_presc");
        wrt(A_COUNT, 1, "t3_count");
        wrt(A_CTRL, 1, "t3_en");
        for (int k = 1; k <= 2 * PW + 5; k++) begin
            if (k == PW + 1)                     rdc(A_COUNT, 1, "t3_before_dec");
            else if (k == PW + 2)                rdc(A_COUNT, 0, "t3_first_dec");
            else if (k <= PW + 2)                rd(A_COUNT, "t3_count_rd");
            else if (k == 2 * PW + 2)            rdc(A_STAT, 0, "t3_before_expiry");
            else if (k == 2 * PW + 3)            rdc(A_STAT, 1, "t3_expiry");
            else                                 rd(A_STAT, "t3_stat_rd");
        end
        wrt(A_STAT, 1, "t3_clr2");

        // Address decode
        wrt(A_COUNT, 32'h1234, "t4_count");
        rdc(32'h1100_0300, 0, "t4_unsel");
        rdc(32'h1100_020B, 32'h1234, "t4_count_alias");
        rd(32'h1100_0208, "t4_count_rd");
        rdc(32'h1100_0214, 0, "t4_past_end");
        rdc(32'h1100_01FC, 0, "t4_before_base");
        rdc(A_PRESC, PRESC_ON ? 32'd4 : 32'd0, "t4_presc");
        wrt(A_CTRL, 32'hFFFF_FFF8, "t4_ctrl_hi");
        rdc(A_CTRL, 0, "t4_ctrl_hi_rd");

        // Reset mid-count with INTR high
        wrt(A_STAT, 1, "t5_clr");
        wrt(A_PRESC, 0, "t5_presc");
        wrt(A_LOAD, 2, "t5_load");
        wrt(A_COUNT, 2, "t5_count");
        wrt(A_CTRL, 7, "t5_ctrl");
        for (int k = 1; k <= 4; k++) rd(A_COUNT, "t5_count_rd");
        do_reset();
        rdc(A_CTRL, 0, "t5_ctrl0");
        rdc(A_LOAD, 0, "t5_load0");
        rdc(A_COUNT, 0, "t5_count0");
        rdc(A_STAT, 0, "t5_stat0");
        rdc(A_PRESC, 0, "t5_presc0");
        for (int k = 1; k <= 6; k++) rdc(A_STAT, 0, "t5_no_expiry");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: wrt(A_CTRL, $urandom, "rnd_ctrl");
                1: wrt(A_LOAD, $urandom_range(0, 5), "rnd_load");
                2: wrt(A_COUNT, $urandom_range(0, 6), "rnd_count");
                3: wrt(A_STAT, $urandom_range(0, 3), "rnd_status");
                4: if (!m_en) wrt(A_PRESC, $urandom_range(0, 3), "rnd_presc");
                   else       rd(A_PRESC, "rnd_presc_rd");
                5: rd(B + 32'($urandom_range(0, 31)), "rnd_rd_near");
                6: wrt($urandom, $urandom, "rnd_wr_any");
                default: rd(B + 32'(4 * $urandom_range(0, 4)), "rnd_rd_reg");
            endcase
        end

        @(negedge CLK);
        #1;
        if (q_rd.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain pending %0d want 0", q_rd.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
